// File: rtl/mem_arbiter_if.sv
// Bundle of client-side and memory-side signals for the two-client memory arbiter.
// The arbiter uses the slave modport; whoever drives the clients and memory uses master.
interface mem_arbiter_if;
  // client 0 (instruction cache)
  logic [31:0] i_c0_addr;
  logic        i_c0_ren;
  logic        i_c0_wen;
  logic [31:0] i_c0_wdata;
  logic        i_c0_lock;
  logic        o_c0_ready;
  logic        o_c0_valid;
  logic [31:0] o_c0_rdata;
  // client 1 (data cache)
  logic [31:0] i_c1_addr;
  logic        i_c1_ren;
  logic        i_c1_wen;
  logic [31:0] i_c1_wdata;
  logic        i_c1_lock;
  logic        o_c1_ready;
  logic        o_c1_valid;
  logic [31:0] o_c1_rdata;
  // memory side
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [3:0]  o_mem_mask;
  logic [31:0] o_mem_wdata;
  logic        i_mem_valid;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_c0_addr, i_c0_ren, i_c0_wen, i_c0_wdata, i_c0_lock,
    input  i_c1_addr, i_c1_ren, i_c1_wen, i_c1_wdata, i_c1_lock,
    input  i_mem_ready, i_mem_valid, i_mem_rdata,
    output o_c0_ready, o_c0_valid, o_c0_rdata,
    output o_c1_ready, o_c1_valid, o_c1_rdata,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_mask, o_mem_wdata
  );

  modport master (
    output i_c0_addr, i_c0_ren, i_c0_wen, i_c0_wdata, i_c0_lock,
    output i_c1_addr, i_c1_ren, i_c1_wen, i_c1_wdata, i_c1_lock,
    output i_mem_ready, i_mem_valid, i_mem_rdata,
    input  o_c0_ready, o_c0_valid, o_c0_rdata,
    input  o_c1_ready, o_c1_valid, o_c1_rdata,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_mask, o_mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client round-robin memory arbiter (client 0 = I-cache, client 1 = D-cache).
// A client owns the memory port from grant until it is idle, unlocked and has
// no reads in flight; up to 7 reads may be outstanding.
module mem_arbiter (
  input  logic         i_clk,
  input  logic         i_rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t      state_reg;
  logic        owner_reg;
  logic        last_grant_reg;
  logic [2:0]  cnt_reg;
  logic [2:0]  cnt_next;

  logic [31:0] c_addr  [2];
  logic [31:0] c_wdata [2];
  logic [1:0]  c_ren;
  logic [1:0]  c_wen;
  logic [1:0]  c_lock;
  logic [1:0]  c_req;
  logic [1:0]  c_ready;
  logic [1:0]  c_valid;

  logic        owning;
  logic        cnt_full;
  logic        cnt_nz;
  logic        sel_ren;
  logic        sel_wen;
  logic        sel_lock;
  logic        mem_ren;
  logic        mem_wen;
  logic        rd_issue;
  logic        rsp_take;
  logic        winner;

  assign c_addr[0]  = bus.i_c0_addr;
  assign c_addr[1]  = bus.i_c1_addr;
  assign c_wdata[0] = bus.i_c0_wdata;
  assign c_wdata[1] = bus.i_c1_wdata;
  assign c_ren      = {bus.i_c1_ren,  bus.i_c0_ren};
  assign c_wen      = {bus.i_c1_wen,  bus.i_c0_wen};
  assign c_lock     = {bus.i_c1_lock, bus.i_c0_lock};

  // Outputs are suppressed while reset is held, even before the first edge lands.
  assign owning   = (state_reg == OWN) && !i_rst;
  assign cnt_full = (cnt_reg == 3'd7);
  assign cnt_nz   = (cnt_reg != 3'd0);

  assign sel_ren  = c_ren[owner_reg];
  assign sel_wen  = c_wen[owner_reg];
  assign sel_lock = c_lock[owner_reg];

  // A write wins over a simultaneous read; nothing is presented once the counter is full.
  assign mem_wen  = owning && sel_wen && !cnt_full;
  assign mem_ren  = owning && sel_ren && !sel_wen && !cnt_full;
  assign rd_issue = mem_ren && bus.i_mem_ready;
  assign rsp_take = bus.i_mem_valid && cnt_nz;

  // Round-robin only matters on a tie; otherwise the lone requester wins.
  assign winner = (c_req == 2'b11) ? ~last_grant_reg : c_req[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      assign c_req[gi]   = c_ren[gi] | c_wen[gi] | c_lock[gi];
      assign c_ready[gi] = owning && (owner_reg == 1'(gi)) && bus.i_mem_ready && !cnt_full;
      assign c_valid[gi] = owning && (owner_reg == 1'(gi)) && bus.i_mem_valid && cnt_nz;
    end
  endgenerate

  // Outstanding-read count: issue and response in one cycle cancel; never wraps.
  always_comb begin
    cnt_next = cnt_reg;
    if (rd_issue && !rsp_take) begin
      cnt_next = cnt_reg + 3'd1;
    end else if (!rd_issue && rsp_take) begin
      cnt_next = cnt_reg - 3'd1;
    end
  end

  // Ownership FSM: grant from IDLE, release when the owner is quiet and drained.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= 3'd0;
    end else begin
      cnt_reg <= cnt_next;
      case (state_reg)
        IDLE: begin
          if (|c_req) begin
            state_reg      <= OWN;
            owner_reg      <= winner;
            last_grant_reg <= winner;
          end
        end
        OWN: begin
          if (!sel_ren && !sel_wen && !sel_lock && (cnt_next == 3'd0)) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.o_mem_addr  = owning ? c_addr[owner_reg]  : 32'd0;
  assign bus.o_mem_wdata = owning ? c_wdata[owner_reg] : 32'd0;
  assign bus.o_mem_ren   = mem_ren;
  assign bus.o_mem_wen   = mem_wen;
  assign bus.o_mem_mask  = 4'b1111;

  assign bus.o_c0_ready  = c_ready[0];
  assign bus.o_c1_ready  = c_ready[1];
  assign bus.o_c0_valid  = c_valid[0];
  assign bus.o_c1_valid  = c_valid[1];
  assign bus.o_c0_rdata  = bus.i_mem_rdata;
  assign bus.o_c1_rdata  = bus.i_mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural ownership model checked every cycle,
// a memory model (latency 4, one accept every 2 cycles) and directed scenarios.
module tb_mem_arbiter;
  localparam int LATENCY  = 4;
  localparam int INTERVAL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  logic [31:0] c_addr  [2];
  logic [31:0] c_wdata [2];
  logic [1:0]  c_ren, c_wen, c_lock;
  logic        mem_ready, mem_valid;
  logic [31:0] mem_rdata;

  assign bus.i_c0_addr  = c_addr[0];
  assign bus.i_c1_addr  = c_addr[1];
  assign bus.i_c0_wdata = c_wdata[0];
  assign bus.i_c1_wdata = c_wdata[1];
  assign bus.i_c0_ren   = c_ren[0];
  assign bus.i_c1_ren   = c_ren[1];
  assign bus.i_c0_wen   = c_wen[0];
  assign bus.i_c1_wen   = c_wen[1];
  assign bus.i_c0_lock  = c_lock[0];
  assign bus.i_c1_lock  = c_lock[1];
  assign bus.i_mem_ready = mem_ready;
  assign bus.i_mem_valid = mem_valid;
  assign bus.i_mem_rdata = mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endfunction

  // ---------------- memory model ----------------
  typedef struct { int due; logic [31:0] data; } resp_t;
  resp_t       pendq[$];
  logic [31:0] store [logic [31:0]];
  int          last_acc = -100;
  bit          hold = 1'b0;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (store.exists(a)) return store[a];
    return a ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    mem_ready = ((cyc - last_acc) >= INTERVAL);
    mem_valid = 1'b0;
    mem_rdata = 32'd0;
    if (!hold && pendq.size() > 0 && pendq[0].due <= cyc) begin
      mem_valid = 1'b1;
      mem_rdata = pendq[0].data;
      void'(pendq.pop_front());
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_last = 1;
  int m_infl = 0;
  int vcnt [2] = '{0, 0};
  int rdc  [2] = '{0, 0};
  int wrc  [2] = '{0, 0};
  int c1_rdy_seen = 0;
  logic [31:0] last_rdata [2];

  always @(negedge clk) begin : model_cmp
    logic [1:0]  e_rdy, e_vld, req;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_wdata;
    bit          full, acc, ret;
    e_rdy = 2'b00; e_vld = 2'b00; e_ren = 1'b0; e_wen = 1'b0;
    e_addr = 32'd0; e_wdata = 32'd0;
    full = (m_infl >= 7);
    req = c_ren | c_wen | c_lock;
    if (!rst && m_busy) begin
      e_addr  = c_addr[m_owner];
      e_wdata = c_wdata[m_owner];
      e_wen   = c_wen[m_owner] && !full;
      e_ren   = c_ren[m_owner] && !c_wen[m_owner] && !full;
      e_rdy[m_owner] = mem_ready && !full;
      e_vld[m_owner] = mem_valid && (m_infl > 0);
    end
    check("mem_ren",   32'(bus.o_mem_ren),  32'(e_ren));
    check("mem_wen",   32'(bus.o_mem_wen),  32'(e_wen));
    check("mem_mask",  32'(bus.o_mem_mask), 32'hF);
    check("mem_addr",  bus.o_mem_addr,      e_addr);
    check("mem_wdata", bus.o_mem_wdata,     e_wdata);
    check("c0_ready",  32'(bus.o_c0_ready), 32'(e_rdy[0]));
    check("c1_ready",  32'(bus.o_c1_ready), 32'(e_rdy[1]));
    check("c0_valid",  32'(bus.o_c0_valid), 32'(e_vld[0]));
    check("c1_valid",  32'(bus.o_c1_valid), 32'(e_vld[1]));
    check("c0_rdata",  bus.o_c0_rdata,      mem_rdata);
    check("c1_rdata",  bus.o_c1_rdata,      mem_rdata);

    // advance the model to what must hold after the coming edge
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_last = 1; m_infl = 0;
    end else if (!m_busy) begin
      if (req != 2'b00) begin
        m_owner = (req == 2'b11) ? (1 - m_last) : (req[1] ? 1 : 0);
        m_last  = m_owner;
        m_busy  = 1'b1;
      end
    end else begin
      acc = e_rdy[m_owner] && e_ren;
      ret = mem_valid && (m_infl > 0);
      m_infl = m_infl + int'(acc) - int'(ret);
      if (!c_ren[m_owner] && !c_wen[m_owner] && !c_lock[m_owner] && m_infl == 0) m_busy = 1'b0;
    end

    // observed activity for the directed checks
    if (bus.o_c0_valid) begin vcnt[0]++; last_rdata[0] = bus.o_c0_rdata; end
    if (bus.o_c1_valid) begin vcnt[1]++; last_rdata[1] = bus.o_c1_rdata; end
    if (bus.o_c0_ready && bus.o_mem_ren) rdc[0]++;
    if (bus.o_c1_ready && bus.o_mem_ren) rdc[1]++;
    if (bus.o_c0_ready && bus.o_mem_wen) wrc[0]++;
    if (bus.o_c1_ready && bus.o_mem_wen) wrc[1]++;
    if (bus.o_c1_ready) c1_rdy_seen++;

    // memory accepts what is presented while it is ready
    if (mem_ready && bus.o_mem_wen) begin
      store[bus.o_mem_addr] = bus.o_mem_wdata;
      last_acc = cyc;
    end else if (mem_ready && bus.o_mem_ren) begin
      pendq.push_back('{due: cyc + LATENCY, data: rd_mem(bus.o_mem_addr)});
      last_acc = cyc;
    end
  end

  // ---------------- stimulus helpers (callers sit at posedge+2) ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_inputs();
    c_ren = 2'b00; c_wen = 2'b00; c_lock = 2'b00;
    c_addr[0] = 32'd0; c_addr[1] = 32'd0; c_wdata[0] = 32'd0; c_wdata[1] = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_issue(output int who, output int waited);
    who = -1;
    waited = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if ((bus.o_mem_ren || bus.o_mem_wen) && (bus.o_c0_ready || bus.o_c1_ready)) begin
        who = bus.o_c1_ready ? 1 : 0;
        waited = k;
        break;
      end
    end
    if (who < 0) timeout_fail("issue_wait");
    @(posedge clk); #2;
  endtask

  task automatic wait_valid(input int c, input int target);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (vcnt[c] >= target) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!got) timeout_fail("valid_wait");
    @(posedge clk); #2;
  endtask

  task automatic do_issue(input int c, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input bit lk, output int waited);
    int who;
    c_addr[c] = a; c_wdata[c] = d; c_ren[c] = !wr; c_wen[c] = wr; c_lock[c] = lk;
    wait_issue(who, waited);
    check("issue_client", 32'(who), 32'(c));
    c_ren[c] = 1'b0; c_wen[c] = 1'b0;
    $display("[TB] cyc %0d c%0d %s addr 0x%08h data 0x%08h lock %0d wait %0d",
             cyc, c, wr ? "wr" : "rd", a, d, lk, waited);
  endtask

  task automatic read_word(input int c, input logic [31:0] a, output logic [31:0] data);
    int snap, w;
    snap = vcnt[c];
    do_issue(c, 1'b0, a, 32'd0, 1'b0, w);
    wait_valid(c, snap + 1);
    data = last_rdata[c];
    $display("[TB] cyc %0d c%0d read 0x%08h -> 0x%08h", cyc, c, a, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w, who, s0, s1, s2;
    logic [31:0] d;
    clear_inputs();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Single read by client 1
    s0 = vcnt[0];
    s1 = vcnt[1];
    do_issue(1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, w);
    check("single_grant_latency", 32'(w), 32'd1);
    wait_valid(1, s1 + 1);
    check("single_rdata", last_rdata[1], 32'h1234_5668);
    tick(3);
    check("single_c1_valids", 32'(vcnt[1] - s1), 32'd1);
    check("single_c0_valids", 32'(vcnt[0] - s0), 32'd0);

    // Line fill by client 0 under lock while client 1 waits
    s0 = vcnt[0];
    s1 = vcnt[1];
    s2 = c1_rdy_seen;
    c_ren[1] = 1'b1; c_addr[1] = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      do_issue(0, 1'b0, 32'h40 + 32'(4 * i), 32'd0, 1'b1, w);
    end
    wait_valid(0, s0 + 4);
    check("fill_c1_blocked", 32'(c1_rdy_seen - s2), 32'd0);
    check("fill_last_rdata", last_rdata[0], 32'h1234_5634);
    c_lock[0] = 1'b0;
    do_issue(1, 1'b0, 32'h0000_0100, 32'd0, 1'b0, w);
    check("fill_handover_wait", 32'(w), 32'd2);
    wait_valid(1, s1 + 1);
    check("fill_c1_rdata", last_rdata[1], 32'h1234_5778);
    tick(3);

    // Tie after reset goes to client 0, repeat tie goes to client 1
    do_reset();
    tick(1);
    s0 = vcnt[0];
    c_ren = 2'b11; c_addr[0] = 32'h200; c_addr[1] = 32'h300;
    wait_issue(who, w);
    check("tie_first", 32'(who), 32'd0);
    c_ren[0] = 1'b0;
    wait_valid(0, s0 + 1);
    check("tie_c0_rdata", last_rdata[0], 32'h1234_5478);
    c_ren[0] = 1'b1; c_addr[0] = 32'h204;
    wait_issue(who, w);
    check("tie_repeat", 32'(who), 32'd1);
    c_ren[1] = 1'b0;
    wait_issue(who, w);
    check("tie_after_c1", 32'(who), 32'd0);
    c_ren[0] = 1'b0;
    tick(12);

    // Locked writeback with gaps; client 0 must not slip in between
    s1 = wrc[1];
    do_issue(1, 1'b1, 32'h80, 32'hDEAD_BEEF, 1'b1, w);
    check("wb_grant_latency", 32'(w), 32'd1);
    s0 = rdc[0] + wrc[0];
    c_ren[0] = 1'b1; c_addr[0] = 32'h500;
    tick(2);
    do_issue(1, 1'b1, 32'h84, 32'hCAFE_BEEF, 1'b1, w);
    check("wb_second_wait", 32'(w), 32'd0);
    c_lock[1] = 1'b0;
    check("wb_no_c0_issue", 32'(rdc[0] + wrc[0] - s0), 32'd0);
    check("wb_write_count", 32'(wrc[1] - s1), 32'd2);
    wait_issue(who, w);
    check("wb_c0_after", 32'(who), 32'd0);
    c_ren[0] = 1'b0;
    tick(8);
    read_word(0, 32'h80, d);
    check("wb_readback0", d, 32'hDEAD_BEEF);
    read_word(0, 32'h84, d);
    check("wb_readback1", d, 32'hCAFE_BEEF);
    tick(3);

    // Counter limit with stalled responses
    do_reset();
    tick(1);
    hold = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_issue(0, 1'b0, 32'h600 + 32'(4 * i), 32'd0, 1'b1, w);
    end
    s0 = vcnt[0];
    c_ren[0] = 1'b1; c_addr[0] = 32'h700;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("limit_ready_low", 32'(bus.o_c0_ready), 32'd0);
      check("limit_ren_low", 32'(bus.o_mem_ren), 32'd0);
    end
    @(posedge clk); #2;
    mem_valid = 1'b1; mem_rdata = 32'h55;
    @(negedge clk); #1;
    check("limit_valid", 32'(bus.o_c0_valid), 32'd1);
    check("limit_valid_rdata", bus.o_c0_rdata, 32'h55);
    wait_issue(who, w);
    check("limit_reenable", 32'(w), 32'd0);
    c_ren[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_valid = 1'b1; mem_rdata = 32'(i);
      tick(1);
    end
    mem_valid = 1'b1; mem_rdata = 32'hBAD;
    @(negedge clk); #1;
    check("stray_valid", 32'(bus.o_c0_valid), 32'd0);
    @(posedge clk); #2;
    @(negedge clk); #1;
    check("stray_no_wrap", 32'(bus.o_c0_ready), 32'd1);
    check("limit_valid_count", 32'(vcnt[0] - s0), 32'd8);
    @(posedge clk); #2;
    c_lock[0] = 1'b0;
    pendq.delete();
    hold = 1'b0;
    tick(3);

    // Reset in the middle of a locked fill
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_issue(1, 1'b0, 32'h900 + 32'(4 * i), 32'd0, 1'b1, w);
    end
    rst = 1'b1;
    clear_inputs();
    @(negedge clk); #1;
    check("rst_ren", 32'(bus.o_mem_ren), 32'd0);
    check("rst_ready", 32'(bus.o_c1_ready), 32'd0);
    @(posedge clk); #2;
    tick(1);
    rst = 1'b0;
    hold = 1'b0;
    s0 = vcnt[0] + vcnt[1];
    tick(12);
    check("rst_late_dropped", 32'(vcnt[0] + vcnt[1] - s0), 32'd0);
    c_ren = 2'b11; c_addr[0] = 32'hA00; c_addr[1] = 32'hA04;
    wait_issue(who, w);
    check("rst_tie_c0", 32'(who), 32'd0);
    c_ren[0] = 1'b0;
    wait_issue(who, w);
    check("rst_then_c1", 32'(who), 32'd1);
    c_ren[1] = 1'b0;
    tick(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
